// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the multi-cycle datapath controller and the ALU execution unit.
// The controller drives the operation request; the unit returns the registered result and flags.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             sign;
  logic             illegal;

  modport master (
    output start, ctrl, a, b,
    input  busy, done, result, zero, carry, sign, illegal
  );

  modport slave (
    input  start, ctrl, a, b,
    output busy, done, result, zero, carry, sign, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arithmetic ops and iterative one-bit-per-cycle shifts.
// The result and flags are registered and only change on a completion edge or on reset.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  alu_exec_unit_if.slave bus
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_COMP = 5'b01100;
  localparam logic [4:0] OP_AND  = 5'b00001;
  localparam logic [4:0] OP_XOR  = 5'b00010;
  localparam logic [4:0] OP_DIFF = 5'b10000;
  localparam logic [4:0] OP_SHLL = 5'b00011;
  localparam logic [4:0] OP_SHRL = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01111;

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]           sop_q, sop_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 sign_q, sign_d;
  logic                 illegal_q, illegal_d;

  logic [WIDTH:0]       add_w;
  logic [WIDTH:0]       sub_w;
  logic [WIDTH:0]       step_w;
  logic [SHAMT_W-1:0]   shamt_w;

  // One shift position; the bit leaving the register is returned in the top bit.
  function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] val,
                                                input logic [4:0]       op);
    logic signed [WIDTH-1:0] sval;
    sval = $signed(val);
    case (op)
      OP_SHLL: shift_step = {val[WIDTH-1], val[WIDTH-2:0], 1'b0};
      OP_SHRA: shift_step = {val[0], WIDTH'(sval >>> 1)};
      default: shift_step = {val[0], 1'b0, val[WIDTH-1:1]};
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    sop_d     = sop_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    carry_d   = carry_q;
    illegal_d = illegal_q;
    add_w     = {1'b0, bus.a} + {1'b0, bus.b};
    sub_w     = {1'b0, bus.a} - {1'b0, bus.b};
    step_w    = shift_step(shreg_q, sop_q);
    shamt_w   = bus.b[SHAMT_W-1:0];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          done_d    = 1'b1;
          illegal_d = 1'b0;
          carry_d   = 1'b0;
          case (bus.ctrl)
            OP_ADD: begin
              result_d = add_w[WIDTH-1:0];
              carry_d  = add_w[WIDTH];
            end
            OP_COMP: result_d = '0 - bus.b;
            OP_AND:  result_d = bus.a & bus.b;
            OP_XOR:  result_d = bus.a ^ bus.b;
            OP_DIFF: begin
              result_d = sub_w[WIDTH-1:0];
              carry_d  = sub_w[WIDTH];
            end
            OP_SHLL, OP_SHRL, OP_SHRA: begin
              if (shamt_w == '0) begin
                result_d = bus.a;
              end else begin
                // Multi-cycle path: outputs hold until the final shift edge.
                done_d    = 1'b0;
                carry_d   = carry_q;
                illegal_d = illegal_q;
                shreg_d   = bus.a;
                cnt_d     = shamt_w;
                sop_d     = bus.ctrl;
                busy_d    = 1'b1;
                state_d   = SHIFT;
              end
            end
            default: begin
              result_d  = '0;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      SHIFT: begin
        shreg_d = step_w[WIDTH-1:0];
        cnt_d   = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          result_d  = step_w[WIDTH-1:0];
          carry_d   = step_w[WIDTH];
          illegal_d = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    zero_d = done_d ? (result_d == '0)       : zero_q;
    sign_d = done_d ? result_d[WIDTH-1]      : sign_q;
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    cnt_q   <= cnt_d;
    sop_q   <= sop_d;
    if (!rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      sign_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      sign_q    <= sign_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.zero    = zero_q;
  assign bus.carry   = carry_q;
  assign bus.sign    = sign_q;
  assign bus.illegal = illegal_q;

endmodule
